vga_rx_monitor: RTL and testbench

Receive-side checker for the VGA timing interface driven by `vga_controller`. It samples `hs`, `vs` and `blank` on the 25 MHz pixel strobe and checks every line and frame against the 640x480@60 timing. It locks once consecutive frames are clean, then rebuilds the pixel coordinates it observes. Timing errors are reported as sticky flags plus a count, and drive the on-board LEDR/HEX debug outputs at top level.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_span_counter.sv | 46 ++++
 rtl/vga_rx_monitor.sv | 254 +++++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA receive-side timing monitor.
//   - default 640x480@60 timing constants
//   - counter width and saturation value
//   - monitor FSM state type and the per-strobe error vector
package vga_pkg;

  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic hs_err;
    logic vs_err;
    logic width_err;
    logic height_err;
  } err_vec_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_span_counter.sv
// vga_span_counter: 10-bit saturating event counter with a compare-equal
// output against a fixed expected span.
//   clk_i     : system clock
//   rst_n_i   : synchronous active-low reset
//   en_i      : qualifies clr_i/inc_i (pixel strobe)
//   clr_i     : restart the count; with inc_i in the same strobe the
//               count restarts at 1 so the clearing strobe is counted
//   inc_i     : count one event (holds at CNT_MAX)
//   match_o   : count equals MATCH
module vga_span_counter
  import vga_pkg::*;
#(
  parameter int unsigned MATCH = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic match_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = inc_i ? CNT_W'(1) : '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == CNT_W'(MATCH));

endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: checks a received hs/vs/blank stream against VGA timing,
// locks after LOCK_FRAMES clean frames and rebuilds pixel coordinates.
//   Clk, Reset_n        : system clock, synchronous active-low reset
//   pixel_en            : pixel strobe; all other inputs sampled only here
//   hs, vs, blank       : sync (active-low) and visible-pixel qualifier
//   clear_err           : clears sticky flags and err_count
//   RxX, RxY, rx_valid  : coordinates of the pixel sampled in the last strobe
//   locked, frame_done  : lock status, one-cycle pulse per locked vs fall
//   *_err, err_count    : sticky error flags, saturating errored-event count
//
// state   | meaning
// SEARCH  | waiting for a vs fall to establish a frame reference
// MEASURE | checking frames; counting consecutive clean ones
// LOCKED  | timing trusted; errors are reported and drop back to SEARCH
module vga_rx_monitor
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pixel_en,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  input  logic       clear_err,
  output logic [9:0] RxX,
  output logic [9:0] RxY,
  output logic       rx_valid,
  output logic       locked,
  output logic       frame_done,
  output logic       hs_period_err,
  output logic       vs_period_err,
  output logic       width_err,
  output logic       height_err,
  output logic [7:0] err_count
);

  mon_state_t state_q, state_d;
  logic [7:0] good_q, good_d;
  logic       frame_err_q, frame_err_d;

  logic hs_prev_q, hs_prev_d;
  logic vs_prev_q, vs_prev_d;
  logic blank_prev_q, blank_prev_d;
  logic hf_seen_q, hf_seen_d;
  logic hr_seen_q, hr_seen_d;
  logic vf_seen_q, vf_seen_d;

  logic [9:0] rxx_q, rxx_d;
  logic [9:0] rxy_q, rxy_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_done_q, frame_done_d;
  err_vec_t   flags_q, flags_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic hs_fall, hs_rise, vs_fall, bl_rise, bl_fall;
  logic checking, sync_clr;
  logic h_tot_ok, h_sync_ok, act_ok, line_ok, vact_ok;
  err_vec_t err;
  logic any_err;

  assign hs_fall = pixel_en &  hs_prev_q    & ~hs;
  assign hs_rise = pixel_en & ~hs_prev_q    &  hs;
  assign vs_fall = pixel_en &  vs_prev_q    & ~vs;
  assign bl_rise = pixel_en & ~blank_prev_q &  blank;
  assign bl_fall = pixel_en &  blank_prev_q & ~blank;

  assign checking = (state_q != SEARCH);
  // The vs fall that leaves SEARCH restarts every measurement.
  assign sync_clr = (state_q == SEARCH) & vs_fall;

  vga_span_counter #(.MATCH(H_TOTAL)) u_h_cnt (
    .clk_i(Clk), .rst_n_i(Reset_n), .en_i(pixel_en),
    .clr_i(hs_fall | sync_clr), .inc_i(1'b1), .match_o(h_tot_ok)
  );

  vga_span_counter #(.MATCH(H_SYNC)) u_hlow_cnt (
    .clk_i(Clk), .rst_n_i(Reset_n), .en_i(pixel_en),
    .clr_i(hs_fall | sync_clr), .inc_i(~hs), .match_o(h_sync_ok)
  );

  vga_span_counter #(.MATCH(H_ACTIVE)) u_act_cnt (
    .clk_i(Clk), .rst_n_i(Reset_n), .en_i(pixel_en),
    .clr_i(bl_rise | sync_clr), .inc_i(blank), .match_o(act_ok)
  );

  vga_span_counter #(.MATCH(V_TOTAL)) u_line_cnt (
    .clk_i(Clk), .rst_n_i(Reset_n), .en_i(pixel_en),
    .clr_i(vs_fall), .inc_i(hs_fall), .match_o(line_ok)
  );

  vga_span_counter #(.MATCH(V_ACTIVE)) u_vact_cnt (
    .clk_i(Clk), .rst_n_i(Reset_n), .en_i(pixel_en),
    .clr_i(vs_fall), .inc_i(bl_rise), .match_o(vact_ok)
  );

  // Counters compare their pre-strobe value; the first edge of each kind
  // after a restart has no valid reference and is skipped.
  always_comb begin
    err            = '0;
    err.hs_err     = checking & ((hs_fall & hf_seen_q & ~h_tot_ok) |
                                 (hs_rise & hr_seen_q & ~h_sync_ok));
    err.width_err  = checking & bl_fall & ~act_ok;
    err.vs_err     = checking & vs_fall & vf_seen_q & ~line_ok;
    err.height_err = checking & vs_fall & vf_seen_q & ~vact_ok;
  end

  assign any_err = |err;

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_err_d = frame_err_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d     = MEASURE;
          good_d      = '0;
          frame_err_d = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          frame_err_d = 1'b0;
          if (frame_err_q || any_err) begin
            good_d = '0;
          end else if ((good_q + 8'd1) >= 8'(LOCK_FRAMES)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end else if (any_err) begin
          frame_err_d = 1'b1;
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    blank_prev_d = blank_prev_q;
    hf_seen_d    = hf_seen_q;
    hr_seen_d    = hr_seen_q;
    vf_seen_d    = vf_seen_q;
    rxx_d        = rxx_q;
    rxy_d        = rxy_q;
    rx_valid_d   = rx_valid_q;
    flags_d      = flags_q;
    err_cnt_d    = err_cnt_q;
    frame_done_d = 1'b0;
    if (pixel_en) begin
      hs_prev_d    = hs;
      vs_prev_d    = vs;
      blank_prev_d = blank;

      if (sync_clr) begin
        hf_seen_d = 1'b0;
        hr_seen_d = 1'b0;
        vf_seen_d = 1'b0;
      end else begin
        if (hs_fall) hf_seen_d = 1'b1;
        if (hs_rise) hr_seen_d = 1'b1;
        if (vs_fall) vf_seen_d = 1'b1;
      end

      if (bl_rise) begin
        rxx_d = '0;
      end else if (blank) begin
        rxx_d = rxx_q + 10'd1;
      end

      if (vs_fall) begin
        rxy_d = '0;
      end else if (bl_fall) begin
        rxy_d = rxy_q + 10'd1;
      end

      // Clear first so a simultaneous locked error still lands.
      if (clear_err) begin
        flags_d   = '0;
        err_cnt_d = '0;
      end
      if ((state_q == LOCKED) && any_err) begin
        flags_d   = flags_d | err;
        err_cnt_d = sat_inc8(err_cnt_d);
      end

      rx_valid_d   = (state_d == LOCKED) & blank;
      frame_done_d = (state_q == LOCKED) & vs_fall & ~any_err;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= SEARCH;
      good_q       <= '0;
      frame_err_q  <= 1'b0;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      blank_prev_q <= 1'b0;
      hf_seen_q    <= 1'b0;
      hr_seen_q    <= 1'b0;
      vf_seen_q    <= 1'b0;
      rxx_q        <= '0;
      rxy_q        <= '0;
      rx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      flags_q      <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      frame_err_q  <= frame_err_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      blank_prev_q <= blank_prev_d;
      hf_seen_q    <= hf_seen_d;
      hr_seen_q    <= hr_seen_d;
      vf_seen_q    <= vf_seen_d;
      rxx_q        <= rxx_d;
      rxy_q        <= rxy_d;
      rx_valid_q   <= rx_valid_d;
      frame_done_q <= frame_done_d;
      flags_q      <= flags_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign RxX           = rxx_q;
  assign RxY           = rxy_q;
  assign rx_valid      = rx_valid_q;
  assign locked        = (state_q == LOCKED);
  assign frame_done    = frame_done_q;
  assign hs_period_err = flags_q.hs_err;
  assign vs_period_err = flags_q.vs_err;
  assign width_err     = flags_q.width_err;
  assign height_err    = flags_q.height_err;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a scaled-down raster:
// 8 strobes/line (4 visible, hs low at 5..6), 6 lines/frame (3 visible,
// vs low on line 4). Expected values are worked out by hand from that raster.
module tb_vga_rx_monitor;

  localparam int HT      = 8;
  localparam int HA      = 4;
  localparam int HS      = 2;
  localparam int HSF     = 5;
  localparam int VT      = 6;
  localparam int VA      = 3;
  localparam int VS_LINE = 4;
  localparam int NO      = -1;

  logic       clk;
  logic       Reset_n, pixel_en, hs, vs, blank, clear_err;
  logic [9:0] RxX, RxY;
  logic       rx_valid, locked, frame_done;
  logic       hs_period_err, vs_period_err, width_err, height_err;
  logic [7:0] err_count;

  int n_chk;
  int n_err;
  int gap;

  logic       s_locked, s_valid, s_fd, s_fd_next;
  logic       s_hse, s_vse, s_we, s_he;
  logic [9:0] s_rxx, s_rxy;
  logic [7:0] s_cnt;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC(HS),
    .V_TOTAL(VT), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .Clk(clk), .Reset_n(Reset_n), .pixel_en(pixel_en),
    .hs(hs), .vs(vs), .blank(blank), .clear_err(clear_err),
    .RxX(RxX), .RxY(RxY), .rx_valid(rx_valid), .locked(locked),
    .frame_done(frame_done), .hs_period_err(hs_period_err),
    .vs_period_err(vs_period_err), .width_err(width_err),
    .height_err(height_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic take_snap();
    s_locked = locked;  s_valid = rx_valid; s_fd = frame_done;
    s_hse = hs_period_err; s_vse = vs_period_err;
    s_we = width_err;   s_he = height_err;
    s_rxx = RxX; s_rxy = RxY; s_cnt = err_count;
    s_fd_next = 1'b0;
  endtask

  // One frame of strobes. short_line drops its last strobe, bad_act_line
  // has one visible strobe too few, clr/rst pulse at the given line, and a
  // snapshot of the outputs is taken right after strobe (snap_line, snap_hc).
  task automatic send_frame(input int n_lines, input int short_line,
                            input int bad_act_line, input int clr_line,
                            input int rst_line, input int snap_line,
                            input int snap_hc);
    for (int v = 0; v < n_lines; v++) begin
      int hlen;
      int alen;
      hlen = (v == short_line) ? HT - 1 : HT;
      alen = (v == bad_act_line) ? HA - 1 : HA;
      for (int h = 0; h < hlen; h++) begin
        hs        = !((h >= HSF) && (h < HSF + HS));
        vs        = (v != VS_LINE);
        blank     = (v < VA) && (h < alen);
        clear_err = (v == clr_line) && (h == HSF);
        Reset_n   = !((v == rst_line) && (h == 0));
        pixel_en  = 1'b1;
        @(posedge clk); #1;
        pixel_en  = 1'b0;
        clear_err = 1'b0;
        Reset_n   = 1'b1;
        if ((v == snap_line) && (h == snap_hc)) take_snap();
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          if ((g == 0) && (v == snap_line) && (h == snap_hc)) s_fd_next = frame_done;
        end
      end
    end
  endtask

  task automatic clean_frame();
    send_frame(VT, NO, NO, NO, NO, NO, NO);
  endtask

  task automatic vs_snap_frame();
    send_frame(VT, NO, NO, NO, NO, VS_LINE, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0; gap = 1;
    Reset_n = 1'b0; pixel_en = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_rxx", RxX, 0);
    chk("rst_rxy", RxY, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_flags", {hs_period_err, vs_period_err, width_err, height_err}, 0);
    Reset_n = 1'b1;

    // acquisition: lock one cycle after the 3rd vs fall
    vs_snap_frame(); chk("lock_vs1", s_locked, 0);
    vs_snap_frame(); chk("lock_vs2", s_locked, 0);
    vs_snap_frame(); chk("lock_vs3", s_locked, 1);

    send_frame(VT, NO, NO, NO, NO, 1, 2);
    chk("coord_x", s_rxx, 2);
    chk("coord_y", s_rxy, 1);
    chk("coord_valid", s_valid, 1);

    send_frame(VT, NO, NO, NO, NO, 1, 6);
    chk("blank_valid", s_valid, 0);
    chk("blank_xhold", s_rxx, 3);

    vs_snap_frame();
    chk("fdone_pulse", s_fd, 1);
    chk("fdone_next", s_fd_next, 0);

    // short line while locked
    send_frame(VT, 1, NO, NO, NO, 2, HSF);
    chk("herr_flag", s_hse, 1);
    chk("herr_cnt", s_cnt, 1);
    chk("herr_locked", s_locked, 0);
    chk("herr_wflag", s_we, 0);
    clean_frame();
    vs_snap_frame();
    chk("herr_relock", s_locked, 1);
    chk("herr_cnt_keep", s_cnt, 1);

    // clear on a clean strobe
    send_frame(VT, NO, NO, 0, NO, 0, HSF);
    chk("clr_flag", s_hse, 0);
    chk("clr_cnt", s_cnt, 0);

    // short visible run, then a short frame
    send_frame(VT, NO, 1, NO, NO, 1, HA - 1);
    chk("werr_flag", s_we, 1);
    chk("werr_cnt", s_cnt, 1);
    chk("werr_locked", s_locked, 0);
    clean_frame();
    vs_snap_frame();
    chk("werr_relock", s_locked, 1);
    send_frame(VT - 1, NO, NO, NO, NO, NO, NO);
    vs_snap_frame();
    chk("verr_flag", s_vse, 1);
    chk("verr_cnt", s_cnt, 2);
    chk("verr_height", s_he, 0);
    chk("verr_locked", s_locked, 0);

    // errored frame during MEASURE delays lock by one frame, sets nothing
    clean_frame();
    send_frame(VT, 1, NO, NO, NO, VS_LINE, 0);
    chk("meas_locked", s_locked, 0);
    chk("meas_hflag", s_hse, 0);
    chk("meas_cnt", s_cnt, 2);
    vs_snap_frame(); chk("meas_delay", s_locked, 0);
    vs_snap_frame(); chk("meas_lock", s_locked, 1);

    // one-cycle reset mid-frame while locked
    send_frame(VT, NO, NO, NO, 1, 1, 0);
    chk("mrst_locked", s_locked, 0);
    chk("mrst_cnt", s_cnt, 0);
    chk("mrst_flags", {s_hse, s_vse, s_we, s_he}, 0);
    chk("mrst_rxy", s_rxy, 0);
    chk("mrst_valid", s_valid, 0);
    vs_snap_frame(); chk("mrst_vs2", s_locked, 0);
    vs_snap_frame(); chk("mrst_vs3", s_locked, 1);

    // five errors, then clear together with a sixth
    for (int i = 0; i < 5; i++) begin
      send_frame(VT, 1, NO, NO, NO, NO, NO);
      clean_frame();
      vs_snap_frame();
    end
    chk("five_cnt", s_cnt, 5);
    chk("five_locked", s_locked, 1);
    send_frame(VT, 1, NO, 2, NO, 2, HSF);
    chk("clrwin_flag", s_hse, 1);
    chk("clrwin_cnt", s_cnt, 1);
    chk("clrwin_locked", s_locked, 0);

    // saturation with back-to-back strobes
    gap = 0;
    clean_frame();
    vs_snap_frame();
    chk("sat_relock", s_locked, 1);
    for (int i = 0; i < 259; i++) begin
      send_frame(VT, 1, NO, NO, NO, NO, NO);
      clean_frame();
      vs_snap_frame();
      if (i == 252) chk("sat_254", s_cnt, 254);
    end
    chk("sat_255", s_cnt, 255);
    chk("sat_locked", s_locked, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
